// File: rtl/snake_body_engine.sv
// snake_body_engine: snake head/body movement, growth, self-collision and wall check, body streaming.
// Optional feature macro SNAKE_WRAP_EN: head wraps at grid edges instead of hitting a wall.
module snake_body_engine #(
    parameter int SNAKE_LENGTH_BIT = 4,
    parameter int SNAKE_LENGTH_MAX = 16,
    parameter int GRID_W           = 124,
    parameter int GRID_H           = 81,
    parameter int START_X          = 20,
    parameter int START_Y          = 40,
    parameter int START_LENGTH     = 3
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        move_tick,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic                        grow,
    output logic [6:0]                  snake_head_x,
    output logic [6:0]                  snake_head_y,
    output logic                        dir_up,
    output logic                        dir_down,
    output logic                        dir_left,
    output logic                        dir_right,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic [SNAKE_LENGTH_BIT-1:0] body_count,
    output logic [6:0]                  snake_body_x,
    output logic [6:0]                  snake_body_y,
    output logic                        busy,
    output logic                        collision,
    output logic                        wall_hit,
    output logic                        game_over
);
    localparam int N = SNAKE_LENGTH_MAX - 1;
    localparam logic [SNAKE_LENGTH_BIT-1:0] LAST = SNAKE_LENGTH_BIT'(N - 1);
    localparam logic [SNAKE_LENGTH_BIT-1:0] LMAX = SNAKE_LENGTH_BIT'(N);
    typedef enum logic [1:0] {IDLE, CHECK, DEAD} state_t;
    state_t                      state_q;
    logic [6:0]                  hx_q, hy_q, nx_d, ny_d, sbx_q, sby_q;
    logic [6:0]                  bx_q [N];
    logic [6:0]                  by_q [N];
    logic [3:0]                  dir_q, req_d, dir_d;
    logic [SNAKE_LENGTH_BIT-1:0] len_q, k_q, cnt_q, cnt_d;
    logic                        busy_q, col_q, wall_q, gp_q, off_d, wall_d, hit_d;
    // Direction request by priority up > down > right > left; a reversal is refused ({up,down,left,right})
    always_comb begin
        req_d = btn_up ? 4'b1000 : btn_down ? 4'b0100 : btn_right ? 4'b0001 : btn_left ? 4'b0010 : 4'b0000;
        dir_d = (req_d == 4'b0000 || {req_d[2], req_d[3], req_d[0], req_d[1]} == dir_q) ? dir_q : req_d;
    end
    // Candidate next head one block along the current direction, wrapped, plus an off-grid flag
    always_comb begin
        nx_d  = hx_q;
        ny_d  = hy_q;
        off_d = dir_q[3] ? hy_q == 7'd0 : dir_q[2] ? hy_q == 7'(GRID_H - 1) :
                dir_q[1] ? hx_q == 7'd0 : hx_q == 7'(GRID_W - 1);
        if (dir_q[3])      ny_d = off_d ? 7'(GRID_H - 1) : hy_q - 7'd1;
        else if (dir_q[2]) ny_d = off_d ? 7'd0 : hy_q + 7'd1;
        else if (dir_q[1]) nx_d = off_d ? 7'(GRID_W - 1) : hx_q - 7'd1;
        else               nx_d = off_d ? 7'd0 : hx_q + 7'd1;
    end
`ifdef SNAKE_WRAP_EN
    assign wall_d = 1'b0;
`else
    assign wall_d = off_d;
`endif
    assign hit_d = k_q < len_q && bx_q[k_q] == hx_q && by_q[k_q] == hy_q;
    assign cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
    // Direction register and free-running body stream, coordinates registered with their index
    always_ff @(posedge clock_25) begin
        if (reset) begin
            dir_q <= 4'b0001;
            cnt_q <= '0;
            sbx_q <= 7'(START_X - 1);
            sby_q <= 7'(START_Y);
        end else begin
            dir_q <= dir_d;
            cnt_q <= cnt_d;
            sbx_q <= bx_q[cnt_d];
            sby_q <= by_q[cnt_d];
        end
    end
    // Move/check/dead state machine owning head, body array, length and flags
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q <= IDLE;
            hx_q    <= 7'(START_X);
            hy_q    <= 7'(START_Y);
            len_q   <= SNAKE_LENGTH_BIT'(START_LENGTH);
            k_q     <= '0;
            busy_q  <= 1'b0;
            col_q   <= 1'b0;
            wall_q  <= 1'b0;
            gp_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                bx_q[i] <= 7'(START_X - 1 - ((i < START_LENGTH) ? i : START_LENGTH - 1));
                by_q[i] <= 7'(START_Y);
            end
        end else begin
            gp_q <= gp_q | grow;
            case (state_q)
                IDLE: if (move_tick && !(col_q || wall_q)) begin
                    gp_q <= grow;
                    if (wall_d) begin
                        wall_q  <= 1'b1;
                        state_q <= DEAD;
                    end else begin
                        hx_q <= nx_d;
                        hy_q <= ny_d;
                        bx_q[0] <= hx_q;
                        by_q[0] <= hy_q;
                        for (int i = 1; i < N; i++) begin
                            bx_q[i] <= bx_q[i-1];
                            by_q[i] <= by_q[i-1];
                        end
                        if (gp_q && len_q != LMAX) len_q <= len_q + 1'b1;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit_d) col_q <= 1'b1;
                    if (k_q == LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= (col_q || hit_d) ? DEAD : IDLE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    assign snake_head_x = hx_q;
    assign snake_head_y = hy_q;
    assign {dir_up, dir_down, dir_left, dir_right} = dir_q;
    assign snake_length = len_q;
    assign body_count   = cnt_q;
    assign snake_body_x = sbx_q;
    assign snake_body_y = sby_q;
    assign busy         = busy_q;
    assign collision    = col_q;
    assign wall_hit     = wall_q;
    assign game_over    = col_q | wall_q;
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed scoreboard bench for snake_body_engine (honours SNAKE_WRAP_EN).
module tb_snake_body_engine;
    logic       clock_25 = 1'b0, reset = 1'b1, move_tick = 1'b0, grow = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [6:0] snake_head_x, snake_head_y, snake_body_x, snake_body_y;
    logic       dir_up, dir_down, dir_left, dir_right, busy, collision, wall_hit, game_over;
    logic [3:0] snake_length, body_count;
    int         tests = 0, fails = 0, exp_cnt = 0;
    int         mhx, mhy, mlen, mdir;
    int         mbx [15];
    int         mby [15];
    bit         mgp, mcol, mwall;
    typedef struct {int hx; int hy; int len; bit col; bit wall;} exp_t;
    exp_t       sb [$];

    snake_body_engine dut (
        .clock_25(clock_25), .reset(reset), .move_tick(move_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .grow(grow), .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
        .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
        .snake_length(snake_length), .body_count(body_count),
        .snake_body_x(snake_body_x), .snake_body_y(snake_body_y),
        .busy(busy), .collision(collision), .wall_hit(wall_hit), .game_over(game_over)
    );

    always #5 clock_25 = ~clock_25;

    // expected stream index: 0 under reset, then counts 0..14 and wraps
    always @(posedge clock_25) exp_cnt <= reset ? 0 : (exp_cnt == 14 ? 0 : exp_cnt + 1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mhx = 20; mhy = 40; mlen = 3; mdir = 3; mgp = 0; mcol = 0; mwall = 0;
        for (int i = 0; i < 15; i++) begin
            mbx[i] = 19 - ((i < 3) ? i : 2);
            mby[i] = 40;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock_25);
        reset = 1'b0;
        model_reset();
    endtask

    // drive buttons; model: 0 up, 1 down, 2 left, 3 right, opposite = d^1
    task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
        int req;
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        req = u ? 0 : d ? 1 : r ? 3 : l ? 2 : -1;
        if (req >= 0 && req != (mdir ^ 1)) mdir = req;
        @(negedge clock_25);
        chk("dir", {dir_up, dir_down, dir_left, dir_right}, 4'b1000 >> mdir);
    endtask

    task automatic tick(input bit g, input bit poke);
        exp_t e;
        int   nx, ny, hi;
        bit   off, acc;
        acc = !(mcol || mwall);
        move_tick = 1'b1;
        grow = g;
        if (acc) begin
            nx = mhx; ny = mhy;
            case (mdir)
                0: ny = mhy - 1;
                1: ny = mhy + 1;
                2: nx = mhx - 1;
                default: nx = mhx + 1;
            endcase
            off = nx < 0 || nx > 123 || ny < 0 || ny > 80;
`ifdef SNAKE_WRAP_EN
            nx = (nx + 124) % 124;
            ny = (ny + 81) % 81;
            off = 0;
`endif
            if (off) mwall = 1;
            else begin
                for (int i = 14; i > 0; i--) begin
                    mbx[i] = mbx[i-1];
                    mby[i] = mby[i-1];
                end
                mbx[0] = mhx; mby[0] = mhy; mhx = nx; mhy = ny;
                if (mgp && mlen < 15) mlen++;
                for (int i = 0; i < mlen; i++)
                    if (mbx[i] == mhx && mby[i] == mhy) mcol = 1;
            end
            mgp = g;
        end else mgp = mgp | g;
        e = '{mhx, mhy, mlen, mcol, mwall};
        sb.push_back(e);
        @(negedge clock_25);
        move_tick = 1'b0;
        grow = 1'b0;
        if (acc && !mwall) begin
            chk("busy_rise", busy, 1);
            hi = 0;
            while (busy && hi < 40) begin
                move_tick = poke && hi == 3;
                hi++;
                @(negedge clock_25);
            end
            move_tick = 1'b0;
            chk("busy_len", hi, 15);
        end else begin
            @(negedge clock_25);
            chk("busy_idle", busy, 0);
        end
        e = sb.pop_front();
        chk("head_x", snake_head_x, e.hx);
        chk("head_y", snake_head_y, e.hy);
        chk("length", snake_length, e.len);
        chk("collision", collision, e.col);
        chk("wall_hit", wall_hit, e.wall);
        chk("game_over", game_over, e.col | e.wall);
    endtask

    task automatic sweep();
        repeat (15) begin
            chk("stream_cnt", body_count, exp_cnt);
            if (exp_cnt < mlen)
                chk("stream_xy", {snake_body_x, snake_body_y}, {7'(mbx[exp_cnt]), 7'(mby[exp_cnt])});
            @(negedge clock_25);
        end
    endtask

    initial begin
        do_reset();
        chk("rst_head_x", snake_head_x, 20);
        chk("rst_head_y", snake_head_y, 40);
        chk("rst_len", snake_length, 3);
        chk("rst_dir", {dir_up, dir_down, dir_left, dir_right}, 4'b0001);
        chk("rst_flags", {busy, collision, wall_hit, game_over}, 0);
        chk("rst_cnt", body_count, 0);
        chk("rst_body0", {snake_body_x, snake_body_y}, {7'd19, 7'd40});
        sweep();
        set_btn(0, 0, 0, 1);
        tick(0, 1);
        sweep();
        grow = 1'b1;
        mgp = 1;
        @(negedge clock_25);
        grow = 1'b0;
        tick(0, 0);
        sweep();
        tick(0, 0);
        set_btn(0, 0, 1, 0);
        tick(0, 0);
        tick(1, 0);
        set_btn(1, 0, 1, 1);
        tick(0, 0);
        set_btn(0, 0, 1, 0);
        tick(0, 0);
        set_btn(0, 1, 1, 0);
        tick(0, 0);
        sweep();
        tick(0, 0);
        do_reset();
        set_btn(0, 0, 0, 1);
        move_tick = 1'b1;
        @(negedge clock_25);
        move_tick = 1'b0;
        repeat (4) @(negedge clock_25);
        chk("mid_busy", busy, 1);
        do_reset();
        chk("mid_rst_head", {snake_head_x, snake_head_y}, {7'd20, 7'd40});
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_len", snake_length, 3);
        for (int i = 0; i < 103; i++) tick(0, 0);
        chk("edge_head_x", snake_head_x, 123);
        tick(0, 0);
        sweep();
        tick(0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
